mem_access_unit: RTL

Multi-cycle data-memory access unit: the responder to the decoder's memory-control outputs (`readMem`, `writeMem`, `accessMemLen`, `memSigned`). It accepts one load or store per request and checks alignment. It performs byte-lane steering and the DataBus handshake, then returns the sign- or zero-extended load data or an error flag. It sits in the CPU's memory stage and stalls the pipeline through `busy` while a transaction is outstanding.

---
 rtl/mem_access_unit_pkg.sv | 26 ++
 rtl/mem_lane_align.sv | 78 +++++++
 rtl/mem_access_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
//   Shared definitions for the data-memory access unit: the access-length
//   encodings driven by the decoder (accessMemLen) and an alignment helper.
//   No ports.
package mem_access_unit_pkg;

  // Access-length encodings on accessMemLen.
  localparam logic [1:0] MEM_LEN_B    = 2'd0;
  localparam logic [1:0] MEM_LEN_H    = 2'd1;
  localparam logic [1:0] MEM_LEN_W    = 2'd2;
  localparam logic [1:0] MEM_LEN_RSVD = 2'd3;

  // True when an access of length len at byte offset off is legal.
  // The reserved length is never legal, so it takes the address-error path.
  function automatic logic access_aligned(input logic [1:0] len, input logic [1:0] off);
    logic ok;
    case (len)
      MEM_LEN_B: ok = 1'b1;
      MEM_LEN_H: ok = ~off[0];
      MEM_LEN_W: ok = (off == 2'b00);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
//   Purely combinational little-endian byte-lane steering for a 32-bit bus.
//   Stores: produces byte enables and lane-replicated write data.
//   Loads:  extracts the byte/halfword at the given offset and sign- or
//           zero-extends it; words pass through unchanged.
// Ports:
//   offset_i     [1:0]  byte offset within the word (addr[1:0])
//   len_i        [1:0]  access length (MEM_LEN_*)
//   signed_i            sign-extend loaded byte/halfword
//   store_data_i [31:0] right-justified store data
//   bus_rdata_i  [31:0] raw word read from the bus
//   be_o         [3:0]  byte enables (bit n covers bits 8n+7:8n)
//   wdata_o      [31:0] steered store data
//   rdata_o      [31:0] extended load data
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic [1:0]  len_i,
  input  logic        signed_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] bus_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (offset_i)
      2'd0: byte_sel = bus_rdata_i[7:0];
      2'd1: byte_sel = bus_rdata_i[15:8];
      2'd2: byte_sel = bus_rdata_i[23:16];
      2'd3: byte_sel = bus_rdata_i[31:24];
      default: byte_sel = 8'h00;
    endcase
    // Halfwords are only legal at offsets 0 and 2, so offset_i[1] picks the half.
    half_sel = offset_i[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
  end

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0;
    rdata_o = 32'h0;
    case (len_i)
      MEM_LEN_B: begin
        be_o    = 4'b0001 << offset_i;
        // Replicating on every lane lets the slave ignore the offset entirely.
        wdata_o = {4{store_data_i[7:0]}};
        rdata_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      end
      MEM_LEN_H: begin
        be_o    = 4'b0011 << offset_i;
        wdata_o = {2{store_data_i[15:0]}};
        rdata_o = {{16{signed_i & half_sel[15]}}, half_sel};
      end
      MEM_LEN_W: begin
        be_o    = 4'b1111;
        wdata_o = store_data_i;
        rdata_o = bus_rdata_i;
      end
      MEM_LEN_RSVD: begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        rdata_o = 32'h0;
      end
      default: begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        rdata_o = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory-stage load/store responder. Accepts one request per start in IDLE,
//   checks alignment, drives a req/ack data bus with steered lanes, and
//   returns extended load data or an address/bus error with a done pulse.
//   All outputs are registered.
// Parameters:
//   TIMEOUT  bus cycles (>= 1) to wait for bus_ack before flagging busErr
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start                      request strobe (sampled only in IDLE)
//   readMem, writeMem          load / store request (store wins if both)
//   accessMemLen [1:0]         B/H/W/reserved
//   memSigned                  sign-extend loads
//   addr [31:0], wdata [31:0]  byte address, right-justified store data
//   busy, done                 stall indicator, one-cycle completion pulse
//   rdata [31:0]               load result (held until the next done)
//   addrErr, busErr            error flags (held until the next done)
//   bus_req, bus_we, bus_addr, bus_be, bus_wdata   bus request side
//   bus_ack, bus_rdata                             bus response side
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        readMem,
  input  logic        writeMem,
  input  logic [1:0]  accessMemLen,
  input  logic        memSigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addrErr,
  output logic        busErr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        off_q;
  logic [1:0]        len_q;
  logic              signed_q;

  logic              busy_q, done_q, addr_err_q, bus_err_q;
  logic              bus_req_q, bus_we_q;
  logic [31:0]       rdata_q, bus_addr_q, bus_wdata_q;
  logic [3:0]        bus_be_q;

  // Lane aligner is shared: in IDLE it sees the incoming request to build
  // be/wdata; in BUS it sees the latched request to extract load data.
  logic [1:0]        la_off_d, la_len_d;
  logic              la_signed_d;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata, lane_rdata;

  always_comb begin
    la_off_d    = addr[1:0];
    la_len_d    = accessMemLen;
    la_signed_d = memSigned;
    if (state_q != ST_IDLE) begin
      la_off_d    = off_q;
      la_len_d    = len_q;
      la_signed_d = signed_q;
    end
  end

  mem_lane_align u_lane_align (
    .offset_i     (la_off_d),
    .len_i        (la_len_d),
    .signed_i     (la_signed_d),
    .store_data_i (wdata),
    .bus_rdata_i  (bus_rdata),
    .be_o         (lane_be),
    .wdata_o      (lane_wdata),
    .rdata_o      (lane_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      off_q       <= 2'b00;
      len_q       <= MEM_LEN_B;
      signed_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      rdata_q     <= 32'h0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'h0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && (readMem || writeMem)) begin
            busy_q <= 1'b1;
            if (!access_aligned(accessMemLen, addr[1:0])) begin
              // Rejected before touching the bus.
              state_q    <= ST_DONE;
              done_q     <= 1'b1;
              addr_err_q <= 1'b1;
              bus_err_q  <= 1'b0;
            end else begin
              state_q     <= ST_BUS;
              cnt_q       <= '0;
              off_q       <= addr[1:0];
              len_q       <= accessMemLen;
              signed_q    <= memSigned;
              bus_req_q   <= 1'b1;
              bus_we_q    <= writeMem;  // store takes priority over load
              bus_addr_q  <= {addr[31:2], 2'b00};
              bus_be_q    <= lane_be;
              bus_wdata_q <= lane_wdata;
            end
          end
        end
        ST_BUS: begin
          // Ack is checked first so an ack on the final count still completes.
          if (bus_ack) begin
            state_q    <= ST_DONE;
            bus_req_q  <= 1'b0;
            done_q     <= 1'b1;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
            if (!bus_we_q) begin
              rdata_q <= lane_rdata;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q    <= ST_DONE;
            bus_req_q  <= 1'b0;
            done_q     <= 1'b1;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign addrErr   = addr_err_q;
  assign busErr    = bus_err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule
